mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the shared memory port behind the direct-mapped preload cache.
- Master 0 is the instruction-cache memory side; master 1 is the data/uncached path.
- Uses the same valid/ready/addr/size/rdata beat protocol on all ports.
- Round-robin grant with bounded hold, so a long cache line fill cannot starve the other master.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BEATS, 16, maximum consecutive completed beats per grant while the other master waits. Must be >= 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- m0_valid  input  1  master 0 request
- m0_ready  output  1  master 0 beat complete
- m0_addr  input  AW  master 0 address
- m0_size  input  2  master 0 size
- m0_rdata  output  DW  master 0 read data
- m1_valid, m1_ready, m1_addr, m1_size, m1_rdata: same as master 0, for master 1
- mem_valid  output  1  slave request
- mem_ready  input  1  slave beat complete
- mem_addr  output  AW  slave address
- mem_size  output  2  slave size
- mem_rdata  input  DW  slave read data
- gnt  output  2  one-hot current grant; 00 when idle

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, gnt=00, last=1 (master 0 wins first contention), beat_cnt=0.
  - Outputs: mem_valid=0, mem_addr=0, mem_size=0, m0_ready=0, m1_ready=0.
- Beat protocol:
  - A master holds valid/addr/size stable until its ready=1.
  - A beat completes in the cycle valid&ready=1.
  - Dropping valid before ready is a protocol violation; the bench asserts on it.
- States: IDLE, G0, G1. State is registered, so there is 1 cycle of arbitration latency from IDLE.
- IDLE:
  - Nothing forwarded.
  - Only m0_valid -> G0. Only m1_valid -> G1.
  - Both -> the master != last.
  - beat_cnt <= 0.
- Gx forwarding (combinational):
  - mem_valid=mx_valid, mem_addr=mx_addr, mem_size=mx_size.
  - mx_ready=mem_ready; the other ready=0.
  - mem_rdata drives both m0_rdata and m1_rdata. It is only meaningful with the matching ready.
- Gx on a completed beat:
  - beat_cnt increments, saturating at MAX_BEATS.
  - last <= x.
- Gx transitions, priority order:
  1. mx_valid=0: other master valid -> G(other) directly with no dead cycle, beat_cnt<=0; otherwise -> IDLE.
  2. A beat completes making beat_cnt reach MAX_BEATS, and the other master is valid -> G(other), beat_cnt<=0.
  3. Otherwise stay in Gx.
- Hold limit when the other master is idle: beat_cnt saturates and the grant is held indefinitely. A later request from the other master preempts at the next completed beat.
- Switching is only at beat boundaries; an in-flight beat (valid high, ready low) is never abandoned.
- beat_cnt width is $clog2(MAX_BEATS+1). MAX_BEATS=1 means strict alternation under contention.
- mem_ready while mem_valid=0 is ignored.
- gnt equals the state encoding (G0=01, G1=10) and is registered.
- Reset mid-beat: returns to IDLE immediately and drops mem_valid. Masters are reset by the same rst_n.

Test Plan:
- Reset, then m0_valid=1 at 0x100, mem_ready after 2 waits:
  - gnt=01 one cycle after valid.
  - mem_addr=0x100, m0_ready pulses with mem_rdata=0xDEADBEEF.
  - m1_ready stays 0.
- m0_valid and m1_valid rise together from reset -> master 0 is granted first. After m0 drops, G1 follows directly with no IDLE cycle.
- MAX_BEATS=4; m0 issues a 16-beat fill while m1 waits:
  - After beat 4, gnt=10 and m1 completes 1 beat.
  - gnt returns to 01 after m1 drops; beat_cnt restarts at 0.
- m0 streams 20 beats alone -> grant is held throughout (beat_cnt saturates at 16). m1 asserts at beat 18 -> switch after beat 18 completes.
- m1 in-flight beat (mem_ready held 0 for 5 cycles) while m0 asserts -> no switch until m1's beat completes. mem_addr stays stable for all 5 cycles.
- rst_n asserted mid-beat in G1 -> mem_valid=0, gnt=00 asynchronously. After release, the first contention grants master 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-master / one-slave arbiter for the shared memory port behind the
// direct-mapped preload cache. Master 0 is the instruction-cache refill side,
// master 1 is the data / uncached path. All three ports use the same
// valid/ready/addr/size/rdata beat protocol: a master holds its request stable
// until ready, and a beat completes in the cycle valid & ready are both high.
//
// Arbitration is round-robin with a bounded hold. A grant is held while its
// master keeps requesting. If the other master is waiting, the grant is handed
// over after MAX_BEATS completed beats so that a long line fill cannot starve
// the other side. If nobody else is waiting, the grant is kept indefinitely.
// Grants only change at beat boundaries.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   m0_valid/m0_ready   master 0 request / beat complete
//   m0_addr, m0_size    master 0 request attributes
//   m0_rdata            master 0 read data (valid only with m0_ready)
//   m1_*                same as m0_* for master 1
//   mem_valid/mem_ready slave request / beat complete
//   mem_addr, mem_size  forwarded request attributes
//   mem_rdata           slave read data, fanned out to both masters
//   gnt                 one-hot registered grant, 00 when idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          m0_valid,
   output logic          m0_ready,
   input  logic [AW-1:0] m0_addr,
   input  logic [1:0]    m0_size,
   output logic [DW-1:0] m0_rdata,

   input  logic          m1_valid,
   output logic          m1_ready,
   input  logic [AW-1:0] m1_addr,
   input  logic [1:0]    m1_size,
   output logic [DW-1:0] m1_rdata,

   output logic          mem_valid,
   input  logic          mem_ready,
   output logic [AW-1:0] mem_addr,
   output logic [1:0]    mem_size,
   input  logic [DW-1:0] mem_rdata,

   output logic [1:0]    gnt
);

   localparam int            CW      = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

   // The state encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G0   = 2'b01,
      G1   = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic          last_q,  last_d;   // master that completed the most recent beat
   logic [CW-1:0] cnt_q,   cnt_d;    // completed beats in the current grant

   // Beat counter saturates so an uncontested stream can run forever; a
   // saturated count still triggers a hand-over on the next completed beat.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;   // master 0 wins the first contention after reset
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (m0_valid && m1_valid)
               state_d = last_q ? G0 : G1;
            else if (m0_valid)
               state_d = G0;
            else if (m1_valid)
               state_d = G1;
         end

         G0: begin
            if (!m0_valid) begin
               // Owner went quiet: hand straight over without an idle cycle.
               cnt_d   = '0;
               state_d = m1_valid ? G1 : IDLE;
            end else if (mem_ready) begin
               last_d = 1'b0;
               cnt_d  = sat_inc(cnt_q);
               if (sat_inc(cnt_q) == CNT_MAX && m1_valid) begin
                  state_d = G1;
                  cnt_d   = '0;
               end
            end
         end

         G1: begin
            if (!m1_valid) begin
               cnt_d   = '0;
               state_d = m0_valid ? G0 : IDLE;
            end else if (mem_ready) begin
               last_d = 1'b1;
               cnt_d  = sat_inc(cnt_q);
               if (sat_inc(cnt_q) == CNT_MAX && m0_valid) begin
                  state_d = G0;
                  cnt_d   = '0;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Request / response forwarding (combinational from the registered grant)
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_size  = '0;
      m0_ready  = 1'b0;
      m1_ready  = 1'b0;

      unique case (state_q)
         G0: begin
            mem_valid = m0_valid;
            mem_addr  = m0_addr;
            mem_size  = m0_size;
            m0_ready  = mem_ready;
         end
         G1: begin
            mem_valid = m1_valid;
            mem_addr  = m1_addr;
            mem_size  = m1_size;
            m1_ready  = mem_ready;
         end
         default: ;
      endcase
   end

   // Read data is shared; each master qualifies it with its own ready.
   assign m0_rdata = mem_rdata;
   assign m1_rdata = mem_rdata;

   assign gnt = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    mv;
   logic [AW-1:0] ma [2];
   logic [1:0]    ms [2];
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic          m0_ready, m1_ready, mem_valid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_size, gnt;

   int rem [2];
   int beats [2];
   int owner, lastw, run;   // reference model: owner -1 idle, else master index
   int n_vec = 0;
   int n_err = 0;
   bit rand_mode = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_valid(mv[0]), .m0_ready(m0_ready), .m0_addr(ma[0]), .m0_size(ms[0]), .m0_rdata(m0_rdata),
      .m1_valid(mv[1]), .m1_ready(m1_ready), .m1_addr(ma[1]), .m1_size(ms[1]), .m1_rdata(m1_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_size(mem_size),
      .mem_rdata(mem_rdata), .gnt(gnt)
   );

   // Masters must hold a pending request stable until ready.
   logic [1:0]    pend;
   logic [AW-1:0] paddr [2];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= '0;
      else begin
         for (int i = 0; i < 2; i++) begin
            if (pend[i])
               assert (mv[i] && ma[i] == paddr[i])
                  else $error("protocol violation: master %0d dropped or changed a pending request", i);
            pend[i]  <= mv[i] && !((i == 0) ? m0_ready : m1_ready);
            paddr[i] <= ma[i];
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic start(input int i, input int n, input logic [AW-1:0] a, input logic [1:0] s);
      rem[i] = n; mv[i] = 1'b1; ma[i] = a; ms[i] = s;
   endtask

   task automatic agent_done(input int i);
      beats[i]++;
      rem[i]--;
      if (rem[i] <= 0) mv[i] = 1'b0;
      else ma[i] = ma[i] + 4;
   endtask

   // Grant rules in plain terms: idle picks the sole requester or the one that
   // did not complete the last beat; an owner keeps the port until it stops
   // requesting, or until it has completed at least MB beats in this tenure
   // while the other master waits.
   task automatic model_step();
      int o;
      if (owner < 0) begin
         run = 0;
         if (mv == 2'b11) owner = (lastw == 1) ? 0 : 1;
         else if (mv[0]) owner = 0;
         else if (mv[1]) owner = 1;
      end else begin
         o = owner;
         if (!mv[o]) begin
            owner = mv[1-o] ? 1 - o : -1;
            run   = 0;
         end else if (mem_ready) begin
            lastw = o;
            run++;
            if (run >= MB && mv[1-o]) begin
               owner = 1 - o;
               run   = 0;
            end
         end
      end
   endtask

   task automatic tick();
      logic d0, d1;
      d0 = mv[0] && m0_ready;
      d1 = mv[1] && m1_ready;
      model_step();
      @(posedge clk);
      #1;
      if (rand_mode) begin
         for (int i = 0; i < 2; i++)
            if (!mv[i] && $urandom_range(3) == 0)
               start(i, int'($urandom_range(8, 1)), $urandom, 2'($urandom_range(3)));
         mem_ready = ($urandom_range(9) < 7);
         mem_rdata = $urandom;
      end
      if (d0) agent_done(0);
      if (d1) agent_done(1);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; mv = '0; rem[0] = 0; rem[1] = 0; beats[0] = 0; beats[1] = 0;
      mem_ready = 1'b0; mem_rdata = '0; rand_mode = 1'b0;
      owner = -1; lastw = 1; run = 0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; #1;
   endtask

   task automatic drain(input string name);
      for (int c = 0; c < 80 && !(mv == 2'b00 && gnt == 2'b00); c++) tick();
      n_vec++; if (gnt !== 2'b00 || mv !== 2'b00) begin n_err++; $display("FAIL %s_drain: gnt=%b valids=%b, want 00/00", name, gnt, mv); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mv = 2'b11; ma[0] = 32'h11; ma[1] = 32'h22; ms[0] = 2'd1; ms[1] = 2'd2;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (gnt !== 2'b00)       begin n_err++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      n_vec++; if (mem_valid !== 1'b0)  begin n_err++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
      n_vec++; if (mem_addr !== '0)     begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      n_vec++; if (mem_size !== 2'b00)  begin n_err++; $display("FAIL reset_mem_size: got %b want 00", mem_size); end
      n_vec++; if (m0_ready !== 1'b0)   begin n_err++; $display("FAIL reset_m0_ready: got %b want 0", m0_ready); end
      n_vec++; if (m1_ready !== 1'b0)   begin n_err++; $display("FAIL reset_m1_ready: got %b want 0", m1_ready); end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      start(0, 1, 32'h100, 2'd2); #1;
      n_vec++; if (gnt !== 2'b00)      begin n_err++; $display("FAIL single_latency_gnt: got %b want 00", gnt); end
      n_vec++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL single_latency_valid: got %b want 0", mem_valid); end
      tick();
      n_vec++; if (gnt !== 2'b01)         begin n_err++; $display("FAIL single_gnt: got %b want 01", gnt); end
      n_vec++; if (mem_valid !== 1'b1)    begin n_err++; $display("FAIL single_mem_valid: got %b want 1", mem_valid); end
      n_vec++; if (mem_addr !== 32'h100)  begin n_err++; $display("FAIL single_addr: got %h want 100", mem_addr); end
      n_vec++; if (mem_size !== 2'd2)     begin n_err++; $display("FAIL single_size: got %0d want 2", mem_size); end
      n_vec++; if (m0_ready !== 1'b0)     begin n_err++; $display("FAIL single_wait1_ready: got %b want 0", m0_ready); end
      tick();
      n_vec++; if (mem_addr !== 32'h100)  begin n_err++; $display("FAIL single_wait2_addr: got %h want 100", mem_addr); end
      n_vec++; if (m0_ready !== 1'b0)     begin n_err++; $display("FAIL single_wait2_ready: got %b want 0", m0_ready); end
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
      n_vec++; if (m0_ready !== 1'b1)          begin n_err++; $display("FAIL single_m0_ready: got %b want 1", m0_ready); end
      n_vec++; if (m0_rdata !== 32'hDEADBEEF)  begin n_err++; $display("FAIL single_rdata: got %h want deadbeef", m0_rdata); end
      n_vec++; if (m1_ready !== 1'b0)          begin n_err++; $display("FAIL single_m1_ready: got %b want 0", m1_ready); end
      tick();
      mem_ready = 1'b0; #1;
      n_vec++; if (beats[0] !== 1)    begin n_err++; $display("FAIL single_beats: got %0d want 1", beats[0]); end
      n_vec++; if (m1_ready !== 1'b0) begin n_err++; $display("FAIL single_m1_ready_after: got %b want 0", m1_ready); end
      tick();
      n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL single_idle_gnt: got %b want 00", gnt); end
   endtask

   task automatic test_contention();
      do_reset();
      mem_ready = 1'b1;
      start(0, 1, 32'hA000, 2'd1); start(1, 1, 32'hB000, 2'd3); #1;
      tick();
      n_vec++; if (gnt !== 2'b01)         begin n_err++; $display("FAIL contend_first_gnt: got %b want 01", gnt); end
      n_vec++; if (mem_addr !== 32'hA000) begin n_err++; $display("FAIL contend_first_addr: got %h want a000", mem_addr); end
      n_vec++; if (m1_ready !== 1'b0)     begin n_err++; $display("FAIL contend_m1_blocked: got %b want 0", m1_ready); end
      tick();
      n_vec++; if (mem_valid !== 1'b0)    begin n_err++; $display("FAIL contend_m0_dropped: got %b want 0", mem_valid); end
      tick();
      n_vec++; if (gnt !== 2'b10)         begin n_err++; $display("FAIL contend_direct_g1: got %b want 10", gnt); end
      n_vec++; if (mem_addr !== 32'hB000) begin n_err++; $display("FAIL contend_g1_addr: got %h want b000", mem_addr); end
      n_vec++; if (mem_size !== 2'd3)     begin n_err++; $display("FAIL contend_g1_size: got %0d want 3", mem_size); end
      n_vec++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin n_err++; $display("FAIL contend_g1_ready: got m0=%b m1=%b want 0/1", m0_ready, m1_ready); end
      drain("contend");
   endtask

   task automatic test_hold_limit();
      do_reset();
      mem_ready = 1'b1;
      start(0, 16, 32'h1000, 2'd2); #1;
      tick();
      start(1, 1, 32'h2000, 2'd2); #1;
      for (int c = 0; c < 30 && gnt == 2'b01; c++) tick();
      n_vec++; if (beats[0] !== MB)       begin n_err++; $display("FAIL hold_beats_before_switch: got %0d want %0d", beats[0], MB); end
      n_vec++; if (gnt !== 2'b10)         begin n_err++; $display("FAIL hold_switch_gnt: got %b want 10", gnt); end
      n_vec++; if (mem_addr !== 32'h2000) begin n_err++; $display("FAIL hold_m1_addr: got %h want 2000", mem_addr); end
      tick();
      n_vec++; if (beats[1] !== 1) begin n_err++; $display("FAIL hold_m1_beats: got %0d want 1", beats[1]); end
      tick();
      n_vec++; if (gnt !== 2'b01)  begin n_err++; $display("FAIL hold_return_gnt: got %b want 01", gnt); end
      start(1, 1, 32'h3000, 2'd2); #1;
      for (int c = 0; c < 30 && gnt == 2'b01; c++) tick();
      n_vec++; if (beats[0] !== 2 * MB) begin n_err++; $display("FAIL hold_count_restart: got %0d want %0d", beats[0], 2 * MB); end
      drain("hold");
   endtask

   task automatic test_saturate();
      do_reset();
      mem_ready = 1'b1;
      start(0, MB + 8, 32'h4000, 2'd2); #1;
      tick();
      for (int c = 0; c < 40 && beats[0] < MB + 3; c++) begin
         n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL sat_held_gnt: got %b want 01 at beat %0d", gnt, beats[0]); end
         tick();
      end
      start(1, 1, 32'h5000, 2'd0); #1;
      n_vec++; if (mem_addr !== 32'h4000 + 4 * (MB + 3)) begin n_err++; $display("FAIL sat_addr: got %h want %h", mem_addr, 32'h4000 + 4 * (MB + 3)); end
      tick();
      n_vec++; if (beats[0] !== MB + 4) begin n_err++; $display("FAIL sat_switch_beat: got %0d want %0d", beats[0], MB + 4); end
      n_vec++; if (gnt !== 2'b10)       begin n_err++; $display("FAIL sat_switch_gnt: got %b want 10", gnt); end
      drain("sat");
   endtask

   task automatic test_inflight();
      do_reset();
      start(1, 1, 32'h5000, 2'd1); #1;
      tick();
      start(0, 2, 32'h6000, 2'd2); #1;
      for (int i = 0; i < 5; i++) begin
         n_vec++; if (gnt !== 2'b10)         begin n_err++; $display("FAIL inflight_gnt: got %b want 10 (cycle %0d)", gnt, i); end
         n_vec++; if (mem_addr !== 32'h5000) begin n_err++; $display("FAIL inflight_addr: got %h want 5000 (cycle %0d)", mem_addr, i); end
         n_vec++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin n_err++; $display("FAIL inflight_ready: got m0=%b m1=%b want 0/0", m0_ready, m1_ready); end
         tick();
      end
      mem_ready = 1'b1; #1;
      n_vec++; if (m1_ready !== 1'b1) begin n_err++; $display("FAIL inflight_complete: got %b want 1", m1_ready); end
      tick();
      n_vec++; if (gnt !== 2'b10) begin n_err++; $display("FAIL inflight_hold_after: got %b want 10", gnt); end
      tick();
      n_vec++; if (gnt !== 2'b01)         begin n_err++; $display("FAIL inflight_to_g0: got %b want 01", gnt); end
      n_vec++; if (mem_addr !== 32'h6000) begin n_err++; $display("FAIL inflight_g0_addr: got %h want 6000", mem_addr); end
      drain("inflight");
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_ready = 1'b1;
      start(0, 1, 32'h7000, 2'd2); #1;
      tick();
      tick();
      mem_ready = 1'b0;
      start(1, 3, 32'h8000, 2'd0); #1;
      tick();
      n_vec++; if (gnt !== 2'b10 || mem_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got gnt=%b valid=%b want 10/1", gnt, mem_valid); end
      rst_n = 1'b0; #1;
      n_vec++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", mem_valid); end
      n_vec++; if (gnt !== 2'b00)      begin n_err++; $display("FAIL rstmid_gnt: got %b want 00", gnt); end
      mv = '0; rem[0] = 0; rem[1] = 0; owner = -1; lastw = 1; run = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      start(0, 1, 32'h9000, 2'd2); start(1, 1, 32'h9100, 2'd2); #1;
      tick();
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rstmid_first_contention: got %b want 01", gnt); end
      mem_ready = 1'b1;
      drain("rstmid");
   endtask

   task automatic test_random();
      logic [1:0]    e_gnt;
      logic          e_val, e_r0, e_r1;
      logic [AW-1:0] e_addr;
      logic [1:0]    e_size;
      do_reset();
      rand_mode = 1'b1;
      mem_ready = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         e_gnt  = (owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
         e_val  = (owner < 0) ? 1'b0 : mv[owner];
         e_addr = (owner < 0) ? '0 : ma[owner];
         e_size = (owner < 0) ? 2'b00 : ms[owner];
         e_r0   = (owner == 0) && mem_ready;
         e_r1   = (owner == 1) && mem_ready;
         n_vec++; if (gnt !== e_gnt)       begin n_err++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, e_gnt); end
         n_vec++; if (mem_valid !== e_val) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, mem_valid, e_val); end
         n_vec++; if (mem_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr c%0d: got %h want %h", c, mem_addr, e_addr); end
         n_vec++; if (mem_size !== e_size) begin n_err++; $display("FAIL rnd_size c%0d: got %b want %b", c, mem_size, e_size); end
         n_vec++; if (m0_ready !== e_r0)   begin n_err++; $display("FAIL rnd_m0_ready c%0d: got %b want %b", c, m0_ready, e_r0); end
         n_vec++; if (m1_ready !== e_r1)   begin n_err++; $display("FAIL rnd_m1_ready c%0d: got %b want %b", c, m1_ready, e_r1); end
         n_vec++; if (m0_rdata !== mem_rdata || m1_rdata !== mem_rdata) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h", c, m0_rdata, m1_rdata, mem_rdata); end
         tick();
      end
      rand_mode = 1'b0;
   endtask

   initial begin
      mv = '0; ma[0] = '0; ma[1] = '0; ms[0] = '0; ms[1] = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      owner = -1; lastw = 1; run = 0;
      test_reset();
      test_single();
      test_contention();
      test_hold_limit();
      test_saturate();
      test_inflight();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
